// File: rtl/life_pkg.sv
// life_pkg: shared FSM state, B3/S23 rule constants and default grid size for the life engine.
package life_pkg;
  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;
  localparam logic [3:0] BIRTH_COUNT = 4'd3;
  localparam logic [3:0] SURVIVE_MIN = 4'd2;
  localparam logic [3:0] SURVIVE_MAX = 4'd3;
  localparam int DEF_GRID_W = 4;
  localparam int DEF_GRID_H = 4;
  function automatic logic next_cell(input logic alive, input logic [3:0] n);
    return alive ? (n >= SURVIVE_MIN && n <= SURVIVE_MAX) : (n == BIRTH_COUNT);
  endfunction
endpackage

// File: rtl/life_engine_if.sv
// life_engine_if: button/frame inputs and display-facing outputs of the life engine.
interface life_engine_if #(parameter int CELLS = 16);
  logic frame_tick;
  logic btn_up, btn_down, btn_left, btn_right;
  logic btn_toggle, btn_clear, btn_run, btn_step;
  logic [CELLS-1:0] vecteur_map;
  logic [31:0] h_position_du_curseur, v_position_du_curseur;
  logic select_affichage;
  logic [15:0] gen_count;
  logic busy;
  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_clear, btn_run, btn_step,
    input vecteur_map, h_position_du_curseur, v_position_du_curseur, select_affichage, gen_count, busy
  );
  modport slave (
    input frame_tick, btn_up, btn_down, btn_left, btn_right, btn_toggle, btn_clear, btn_run, btn_step,
    output vecteur_map, h_position_du_curseur, v_position_du_curseur, select_affichage, gen_count, busy
  );
endinterface

// File: rtl/life_neighbour_count.sv
// life_neighbour_count: live neighbours of one cell; LIFE_TORUS_EN wraps edges, else off-grid cells are dead.
module life_neighbour_count #(
  parameter int GRID_W = 4,
  parameter int GRID_H = 4,
  parameter int CELLS = GRID_W * GRID_H,
  parameter int IW = $clog2(CELLS)
) (
  input  logic [CELLS-1:0] map,
  input  logic [IW-1:0]    idx,
  output logic [3:0]       count
);
  always_comb begin
    int x, y, nx, ny;
    logic [IW-1:0] ni;
    x = int'(idx) % GRID_W;
    y = int'(idx) / GRID_W;
    nx = 0;
    ny = 0;
    ni = '0;
    count = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) begin
`ifdef LIFE_TORUS_EN
          nx = (x + dx + GRID_W) % GRID_W;
          ny = (y + dy + GRID_H) % GRID_H;
          ni = IW'(nx + ny * GRID_W);
          count = count + 4'(map[ni]);
`else
          nx = x + dx;
          ny = y + dy;
          ni = IW'(nx + ny * GRID_W);
          if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) count = count + 4'(map[ni]);
`endif
        end
  end
endmodule

// File: rtl/life_engine.sv
// life_engine: Game-of-Life map, cursor and run/step control, one cell evaluated per clock.
// Optional LIFE_TORUS_EN (in life_neighbour_count) selects a toroidal grid.
module life_engine
  import life_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H,
  parameter int CELLS = GRID_W * GRID_H,
  parameter int FRAMES_PER_GEN = 30,
  parameter logic [CELLS-1:0] INIT_MAP = 'h0070
) (
  input logic clk,
  input logic reset_n,
  life_engine_if.slave bus
);
  localparam int IW = $clog2(CELLS);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int FW = FRAMES_PER_GEN > 1 ? $clog2(FRAMES_PER_GEN) : 1;
  state_t state;
  logic [CELLS-1:0] map, next_map;
  logic [IW-1:0] idx, cur_cell;
  logic [XW-1:0] cx, cx_n;
  logic [YW-1:0] cy, cy_n;
  logic [FW-1:0] fc;
  logic [15:0] gen_count;
  logic [3:0] count;
  logic running, pending, busy, run_trig;
  life_neighbour_count #(.GRID_W(GRID_W), .GRID_H(GRID_H), .CELLS(CELLS), .IW(IW)) u_count (
    .map(map), .idx(idx), .count(count)
  );
  assign cx_n = bus.btn_left && !bus.btn_right ? (cx == '0 ? XW'(GRID_W - 1) : cx - 1'b1)
              : bus.btn_right && !bus.btn_left ? (cx == XW'(GRID_W - 1) ? '0 : cx + 1'b1) : cx;
  assign cy_n = bus.btn_up && !bus.btn_down ? (cy == '0 ? YW'(GRID_H - 1) : cy - 1'b1)
              : bus.btn_down && !bus.btn_up ? (cy == YW'(GRID_H - 1) ? '0 : cy + 1'b1) : cy;
  assign cur_cell = IW'(int'(cy) * GRID_W + int'(cx));
  assign run_trig = running && bus.frame_tick && fc == FW'(FRAMES_PER_GEN - 1);
  // Triggers are registered into pending; only an idle engine consumes one, others are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      map <= INIT_MAP;
      next_map <= '0;
      idx <= '0;
      cx <= '0;
      cy <= '0;
      fc <= '0;
      gen_count <= '0;
      running <= 1'b0;
      pending <= 1'b0;
      busy <= 1'b0;
    end else begin
      cx <= cx_n;
      cy <= cy_n;
      if (bus.btn_run) running <= !running;
      if (bus.btn_run && !running) fc <= '0;
      else if (running && bus.frame_tick) fc <= run_trig ? '0 : fc + 1'b1;
      pending <= state == IDLE && ((bus.btn_step && !running) || run_trig);
      unique case (state)
        IDLE: begin
          if (bus.btn_clear) map <= '0;
          else if (bus.btn_toggle) map[cur_cell] <= ~map[cur_cell];
          if (pending) begin
            state <= CALC;
            idx <= '0;
            busy <= 1'b1;
          end
        end
        CALC: begin
          next_map[idx] <= next_cell(map[idx], count);
          idx <= idx + 1'b1;
          if (idx == IW'(CELLS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          map <= next_map;
          gen_count <= gen_count + 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.vecteur_map = map;
  assign bus.h_position_du_curseur = 32'(cx);
  assign bus.v_position_du_curseur = 32'(cy);
  assign bus.select_affichage = !running;
  assign bus.gen_count = gen_count;
  assign bus.busy = busy;
endmodule
